// File: rtl/i2s_pll_sequencer_pkg.sv
// hdmi_audio_pkg: shared types and default timing constants for the HDMI audio path.
package hdmi_audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } i2s_seq_state_t;

    localparam int DEF_RST_HOLD_CYCLES     = 500;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/i2s_pll_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for single-bit CDC signals into the local clock domain.
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            q_o    <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/i2s_pll_sequencer.sv
// i2s_pll_sequencer: sequences the I2S audio PLL through reset, lock and stability
// qualification before releasing the I2S-domain reset; retries on failure, faults when exhausted.
module i2s_pll_sequencer
    import hdmi_audio_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               audio_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         lock_loss_count
);

    localparam int MAXC = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;
    localparam int RW   = $clog2(MAX_RETRIES+1);

    i2s_seq_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [7:0]     loss_q, loss_d;
    logic           pll_rst_q, audio_rst_q, ready_q, fault_q;
    logic           lock_s, fail;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    // The shared counter free-runs by default; each state clears it on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        loss_d  = loss_q;
        fail    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                ST_RESET:
                    if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                ST_WAIT_LOCK:
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        fail = (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1));
                    end
                ST_STABLE:
                    if (!lock_s) begin
                        fail = 1'b1;
                    end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                ST_RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        loss_d  = loss_q + 8'(loss_q != 8'hff);
                    end
                end
                default: cnt_d = '0;
            endcase
            if (fail) begin
                cnt_d   = '0;
                state_d = (retry_q == RW'(MAX_RETRIES)) ? ST_FAULT : ST_RESET;
                retry_d = retry_q + RW'(retry_q != RW'(MAX_RETRIES));
            end
        end
    end

    // Outputs are flopped from the next-state decode so they change with state_q, glitch-free.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            audio_rst_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= state_d inside {ST_IDLE, ST_RESET, ST_FAULT};
            audio_rst_q <= state_d != ST_RUN;
            ready_q     <= state_d == ST_RUN;
            fault_q     <= state_d == ST_FAULT;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign audio_rst       = audio_rst_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_i2s_pll_sequencer.sv
// tb_i2s_pll_sequencer: directed and randomized bring-up scenarios checked against a
// timestamp-based behavioural model of the sequencer plus hand-computed milestones.
module tb_i2s_pll_sequencer;

    localparam int H = 4, T = 20, S = 8, M = 2;
    localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_STABLE = 3, P_RUN = 4, P_FAULT = 5;

    logic       refclk = 1'b0, rst = 1'b1, enable = 1'b0, pll_locked = 1'b0;
    logic       pll_rst, audio_rst, ready, fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;
    int         checks = 0, errors = 0;

    i2s_pll_sequencer #(
        .RST_HOLD_CYCLES     (H),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (M)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .enable          (enable),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .audio_rst       (audio_rst),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus the edge number it was entered on; pll_locked seen two edges late.
    int m_ph = P_IDLE, m_ent = 0, m_cyc = 0, m_retry = 0, m_llc = 0;
    bit m_q[$];

    task automatic go(input int p);
        m_ph  = p;
        m_ent = m_cyc;
    endtask

    always @(posedge refclk or posedge rst) begin
        bit ls;
        bit fl;
        int el;
        if (rst) begin
            m_ph = P_IDLE; m_ent = 0; m_cyc = 0; m_retry = 0; m_llc = 0;
            m_q = '{1'b0, 1'b0};
        end else begin
            m_cyc++;
            ls = m_q.pop_front();
            m_q.push_back(pll_locked);
            el = m_cyc - m_ent;
            fl = 1'b0;
            if (!enable) begin
                go(P_IDLE);
                m_retry = 0;
            end else if (m_ph == P_IDLE) begin
                go(P_RESET);
                m_retry = 0;
            end else if (m_ph == P_RESET && el == H) begin
                go(P_WAIT);
            end else if (m_ph == P_WAIT) begin
                if (ls) go(P_STABLE);
                else fl = (el == T);
            end else if (m_ph == P_STABLE) begin
                if (!ls) fl = 1'b1;
                else if (el == S) begin
                    go(P_RUN);
                    m_retry = 0;
                end
            end else if (m_ph == P_RUN && !ls) begin
                m_llc = (m_llc < 255) ? m_llc + 1 : 255;
                go(P_RESET);
            end
            if (fl) begin
                if (m_retry == M) go(P_FAULT);
                else begin
                    m_retry++;
                    go(P_RESET);
                end
            end
        end
    end

    always @(negedge refclk) begin
        chk("model pll_rst", pll_rst, int'(m_ph == P_IDLE || m_ph == P_RESET || m_ph == P_FAULT));
        chk("model audio_rst", audio_rst, int'(m_ph != P_RUN));
        chk("model ready", ready, int'(m_ph == P_RUN));
        chk("model fault", fault, int'(m_ph == P_FAULT));
        chk("model retry_count", retry_count, m_retry);
        chk("model lock_loss_count", lock_loss_count, m_llc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic idle_start();
        enable     = 1'b0;
        pll_locked = 1'b0;
        tick(3);
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, ready, 1);
    endtask

    task automatic wait_release(input string name, input int budget);
        int n = 0;
        while (pll_rst && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, pll_rst, 0);
    endtask

    int rate = 1;

    initial begin
        tick(1);
        chk("reset pll_rst", pll_rst, 1);
        chk("reset audio_rst", audio_rst, 1);
        chk("reset ready", ready, 0);
        chk("reset fault", fault, 0);
        chk("reset retry", retry_count, 0);
        chk("reset llc", lock_loss_count, 0);
        rst = 1'b0;

        // nominal bring-up
        idle_start();
        enable = 1'b1;
        tick(4);
        chk("nom hold", pll_rst, 1);
        tick(1);
        chk("nom release", pll_rst, 0);
        tick(10);
        pll_locked = 1'b1;
        tick(10);
        chk("nom ready early", ready, 0);
        chk("nom audio early", audio_rst, 1);
        tick(1);
        chk("nom ready", ready, 1);
        chk("nom audio", audio_rst, 0);
        chk("nom retry", retry_count, 0);

        // never locks
        idle_start();
        enable = 1'b1;
        tick(24);
        chk("nolock retry0", retry_count, 0);
        chk("nolock wait", pll_rst, 0);
        tick(1);
        chk("nolock retry1", retry_count, 1);
        chk("nolock reseq", pll_rst, 1);
        tick(24);
        chk("nolock retry2", retry_count, 2);
        tick(23);
        chk("nolock prefault", fault, 0);
        tick(1);
        chk("nolock fault", fault, 1);
        chk("nolock fault pll_rst", pll_rst, 1);
        chk("nolock fault retry", retry_count, 2);
        tick(10);
        chk("nolock sticky", fault, 1);
        chk("nolock held", pll_rst, 1);
        enable = 1'b0;
        tick(1);
        chk("nolock clear fault", fault, 0);
        chk("nolock idle pll_rst", pll_rst, 1);
        chk("nolock idle retry", retry_count, 0);

        // glitchy lock during STABLE
        idle_start();
        enable = 1'b1;
        tick(5);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        chk("glitch in stable", pll_rst, 0);
        chk("glitch audio", audio_rst, 1);
        tick(1);
        chk("glitch retry", retry_count, 1);
        chk("glitch reseq", pll_rst, 1);
        chk("glitch audio after", audio_rst, 1);

        // lock on the exact timeout cycle of the second attempt
        idle_start();
        enable = 1'b1;
        tick(46);
        pll_locked = 1'b1;
        tick(2);
        chk("edge pre", pll_rst, 0);
        chk("edge pre retry", retry_count, 1);
        tick(1);
        chk("edge stable", pll_rst, 0);
        chk("edge retry kept", retry_count, 1);
        tick(8);
        chk("edge ready", ready, 1);
        chk("edge retry clear", retry_count, 0);

        // randomized soak
        idle_start();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if (pll_rst) begin
                pll_locked = 1'b0;
                rate = $urandom_range(0, 2);
            end else if (!pll_locked) begin
                if (rate == 1) pll_locked = ($urandom_range(0, 3) == 0);
                else if (rate == 2) pll_locked = ($urandom_range(0, 29) == 0);
            end else if ($urandom_range(0, 49) == 0) begin
                pll_locked = 1'b0;
            end
            tick(1);
        end

        // rst mid-WAIT_LOCK
        idle_start();
        enable = 1'b1;
        tick(8);
        chk("rst pre wait", pll_rst, 0);
        rst = 1'b1;
        #1;
        chk("async pll_rst", pll_rst, 1);
        chk("async audio_rst", audio_rst, 1);
        chk("async ready", ready, 0);
        chk("async fault", fault, 0);
        chk("async retry", retry_count, 0);
        chk("async llc", lock_loss_count, 0);
        tick(1);
        rst = 1'b0;

        // enable fall mid-STABLE
        idle_start();
        enable     = 1'b1;
        pll_locked = 1'b1;
        tick(8);
        chk("en stable pll_rst", pll_rst, 0);
        chk("en stable audio", audio_rst, 1);
        enable = 1'b0;
        tick(1);
        chk("en idle pll_rst", pll_rst, 1);
        chk("en idle audio", audio_rst, 1);
        chk("en idle ready", ready, 0);
        chk("en idle fault", fault, 0);

        // repeated lock loss in RUN
        idle_start();
        enable     = 1'b1;
        pll_locked = 1'b1;
        wait_ready("ll bringup", 40);
        for (int k = 0; k < 300; k++) begin
            tick($urandom_range(0, 4));
            pll_locked = 1'b0;
            tick(2);
            chk("ll audio held", audio_rst, 0);
            tick(1);
            chk("ll audio rise", audio_rst, 1);
            chk("ll pll rise", pll_rst, 1);
            wait_release("ll release", 20);
            tick($urandom_range(0, 8));
            pll_locked = 1'b1;
            wait_ready("ll relock", 40);
        end
        chk("ll saturate", lock_loss_count, 255);
        chk("ll no fault", fault, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
